// File: rtl/push_pkg.sv
// Shared types and helpers for the push-button conditioner: channel FSM state encoding
// and the counter-width calculation.
package push_pkg;

  localparam int unsigned NumButtons = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDbPress = 3'd1,
    StHeld    = 3'd2,
    StRepeat  = 3'd3,
    StDbRel   = 3'd4
  } push_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Wide enough to hold the largest terminal count of any state.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/push_channel.sv
// One button: 2-flop synchroniser, polarity normalisation, debounce/auto-repeat FSM.
// fire_o is the combinational pulse decision; the top registers it.
module push_channel
  import push_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEBOUNCE_CYC  = 20000,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic fire_o,
  output logic held_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);
  localparam bit RepeatEn = (REPEAT_DELAY != 0);
  localparam logic Released = ACTIVE_LOW;

  localparam logic [CntW-1:0] CntZero    = '0;
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] DbLast     = CntW'(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] DelayLast  = CntW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

  logic        sync1_q, sync2_q;
  logic        pressed;
  push_state_e state_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= Released;
      sync2_q <= Released;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ Released;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= CntZero;
    end else begin
      case (state_q)
        StIdle: begin
          if (pressed) begin
            state_q <= StDbPress;
            cnt_q   <= CntOne;
          end
        end
        StDbPress: begin
          if (!pressed) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
          end else if (cnt_q == DbLast) begin
            state_q <= StHeld;
            cnt_q   <= CntZero;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHeld: begin
          if (!pressed) begin
            state_q <= StDbRel;
            cnt_q   <= CntOne;
          end else if (RepeatEn && (cnt_q == DelayLast)) begin
            state_q <= StRepeat;
            cnt_q   <= CntZero;
          end else if (RepeatEn) begin
            // With repeat disabled the counter just parks at zero.
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRepeat: begin
          if (!pressed) begin
            state_q <= StDbRel;
            cnt_q   <= CntOne;
          end else if (cnt_q == PeriodLast) begin
            cnt_q <= CntZero;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StDbRel: begin
          if (pressed) begin
            // Release bounce: back to held, repeat delay starts over.
            state_q <= StHeld;
            cnt_q   <= CntZero;
          end else if (cnt_q == DbLast) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= CntZero;
        end
      endcase
    end
  end

  always_comb begin
    fire_o = 1'b0;
    if (pressed) begin
      case (state_q)
        StDbPress: fire_o = (cnt_q == DbLast);
        StHeld:    fire_o = RepeatEn && (cnt_q == DelayLast);
        StRepeat:  fire_o = (cnt_q == PeriodLast);
        default:   fire_o = 1'b0;
      endcase
    end
  end

  assign held_o = (state_q == StHeld) || (state_q == StRepeat) || (state_q == StDbRel);

endmodule

// File: rtl/push_conditioner.sv
// Two conditioned push buttons (up/down) producing single-cycle pulses for the BCD counter
// chain; simultaneous pulses on both channels are dropped and flagged as a conflict.
module push_conditioner
  import push_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEBOUNCE_CYC  = 20000,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Button,
  output logic [1:0] o_Push,
  output logic [1:0] o_Held,
  output logic       o_Conflict
);

  logic [NumButtons-1:0] fire;
  logic [1:0]            push_q;
  logic                  conflict_q;

  for (genvar g = 0; g < NumButtons; g++) begin : g_chan
    push_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk_i   (i_Clk),
      .rst_ni  (i_Rst),
      .button_i(i_Button[g]),
      .fire_o  (fire[g]),
      .held_o  (o_Held[g])
    );
  end

  // Up and down in the same cycle would cancel in the counter; drop both instead.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      push_q     <= 2'b00;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= &fire;
      push_q     <= (&fire) ? 2'b00 : fire;
    end
  end

  assign o_Push     = push_q;
  assign o_Conflict = conflict_q;

endmodule

// File: tb/tb_push_conditioner.sv
// Randomised and directed bench for push_conditioner against a run-length reference model.
module tb_push_conditioner;

  localparam int Db = 4;
  localparam int Rd = 10;
  localparam int Rp = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] press = 2'b00;
  logic [1:0] button;
  logic [1:0] push, held;
  logic       conflict;

  assign button = ~press;

  push_conditioner #(
    .ACTIVE_LOW   (1'b1),
    .DEBOUNCE_CYC (Db),
    .REPEAT_DELAY (Rd),
    .REPEAT_PERIOD(Rp)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst_n),
    .i_Button  (button),
    .o_Push    (push),
    .o_Held    (held),
    .o_Conflict(conflict)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: raw presses delayed two edges, qualified by run lengths of the
  // synchronised level; repeats scheduled as absolute edge numbers.
  logic [1:0] d1, d2;
  bit         m_pressed[2];
  int         m_orun[2], m_zrun[2], m_next[2];
  int         edge_n;
  logic [1:0] exp_push, exp_held;
  logic       exp_conf;

  int ph_push[2], ph_first[2], ph_conf, ph_held, ph_tick;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    d1 = 2'b00;
    d2 = 2'b00;
    edge_n = 0;
    for (int c = 0; c < 2; c++) begin
      m_pressed[c] = 1'b0;
      m_orun[c] = 0;
      m_zrun[c] = 0;
      m_next[c] = 0;
    end
    exp_push = 2'b00;
    exp_held = 2'b00;
    exp_conf = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] s, f;
    s = d2;
    d2 = d1;
    d1 = press;
    f = 2'b00;
    edge_n++;
    for (int c = 0; c < 2; c++) begin
      if (!m_pressed[c]) begin
        m_orun[c] = s[c] ? m_orun[c] + 1 : 0;
        if (m_orun[c] == Db + 1) begin
          m_pressed[c] = 1'b1;
          m_orun[c] = 0;
          m_zrun[c] = 0;
          f[c] = 1'b1;
          m_next[c] = edge_n + Rd;
        end
      end else if (!s[c]) begin
        m_zrun[c]++;
        if (m_zrun[c] == Db + 1) begin
          m_pressed[c] = 1'b0;
          m_zrun[c] = 0;
        end
      end else if (m_zrun[c] != 0) begin
        m_zrun[c] = 0;
        m_next[c] = edge_n + Rd;
      end else if (Rd != 0 && edge_n == m_next[c]) begin
        f[c] = 1'b1;
        m_next[c] = edge_n + Rp;
      end
    end
    exp_conf = f[0] & f[1];
    exp_push = exp_conf ? 2'b00 : f;
    exp_held = {m_pressed[1], m_pressed[0]};
  endtask

  task automatic phase_start();
    ph_push[0] = 0;
    ph_push[1] = 0;
    ph_first[0] = 0;
    ph_first[1] = 0;
    ph_conf = 0;
    ph_held = 0;
    ph_tick = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("push", {6'b0, push}, {6'b0, exp_push});
    check("held", {6'b0, held}, {6'b0, exp_held});
    check("conflict", {7'b0, conflict}, {7'b0, exp_conf});
    ph_tick++;
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        ph_push[c]++;
        if (ph_first[c] == 0) ph_first[c] = ph_tick;
      end
    end
    if (conflict) ph_conf++;
    if (|held) ph_held++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_push", {6'b0, push}, 8'h00);
    check("async_held", {6'b0, held}, 8'h00);
    check("async_conflict", {7'b0, conflict}, 8'h00);
  endtask

  initial begin
    int dur[2];
    model_reset();
    phase_start();
    run(3);
    check("rst_push", {6'b0, push}, 8'h00);
    check("rst_held", {6'b0, held}, 8'h00);
    rst_n = 1'b1;

    // Clean press of up, 8 cycles, then release
    phase_start();
    press = 2'b01;
    run(7);
    check("t1_first_up", 8'(ph_first[0]), 8'd7);
    check("t1_up_count", 8'(ph_push[0]), 8'd1);
    run(1);
    press = 2'b00;
    phase_start();
    run(10);
    check("t2_release_pulses", 8'(ph_push[0]), 8'd0);
    check("t2_held_ticks", 8'(ph_held), 8'd6);

    // Bounce shorter than the debounce window
    phase_start();
    press = 2'b01;
    run(3);
    press = 2'b00;
    run(1);
    press = 2'b01;
    run(2);
    press = 2'b00;
    run(10);
    check("t3_bounce_pulses", 8'(ph_push[0]), 8'd0);
    check("t3_bounce_held", 8'(ph_held), 8'd0);

    // Long hold of down: 7, 17, then every 3 up to 38
    phase_start();
    press = 2'b10;
    run(40);
    check("t4_first_down", 8'(ph_first[1]), 8'd7);
    check("t4_down_count", 8'(ph_push[1]), 8'd9);
    press = 2'b00;
    run(12);

    // Both on the same edge, then offset by one cycle
    phase_start();
    press = 2'b11;
    run(12);
    check("t5_conflicts", 8'(ph_conf), 8'd1);
    check("t5_up_pulses", 8'(ph_push[0]), 8'd0);
    check("t5_down_pulses", 8'(ph_push[1]), 8'd0);
    press = 2'b00;
    run(12);
    phase_start();
    press = 2'b01;
    run(1);
    press = 2'b11;
    run(11);
    check("t5_off_first_up", 8'(ph_first[0]), 8'd7);
    check("t5_off_first_down", 8'(ph_first[1]), 8'd8);
    check("t5_off_conflicts", 8'(ph_conf), 8'd0);
    press = 2'b00;
    run(12);

    // Reset in the middle of auto-repeat, button kept held
    press = 2'b01;
    run(25);
    assert_reset();
    run(3);
    rst_n = 1'b1;
    phase_start();
    run(10);
    check("t6_first_after_rst", 8'(ph_first[0]), 8'd7);
    check("t6_count_after_rst", 8'(ph_push[0]), 8'd1);
    press = 2'b00;
    run(12);

    // Random presses, bounces and long holds with occasional resets
    dur[0] = 0;
    dur[1] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (dur[c] == 0) begin
          press[c] = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                               : int'($urandom_range(1, 8));
        end
        dur[c]--;
      end
      if ($urandom_range(0, 499) == 0) begin
        assert_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
